// File: rtl/lcd_pkg.sv
// Shared definitions for the 8080-style LCD pixel writer: panel command
// bytes, controller state encoding and the RGB888 -> RGB565 packing.
package lcd_pkg;

   // Panel commands issued at the start of every frame
   localparam logic [7:0] CMD_CASET = 8'h2A;  // column address set
   localparam logic [7:0] CMD_PASET = 8'h2B;  // page (row) address set
   localparam logic [7:0] CMD_RAMWR = 8'h2C;  // memory write

   // The window sequence is 11 words; step 10 is the final RAMWR command
   localparam logic [3:0] LAST_WIN_STEP = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SET_WIN = 2'd1,
      ST_STREAM  = 2'd2,
      ST_FINISH  = 2'd3
   } lcd_state_e;

   // Keep the top 5/6/5 bits of each channel
   function automatic logic [15:0] rgb888_to_565(input logic [23:0] rgb);
      return {rgb[23:19], rgb[15:10], rgb[7:3]};
   endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Single-clock pixel FIFO with registered full/empty flags and a
// synchronous flush used to discard leftovers at the end of a frame.
module pixel_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 24
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_full;
   logic             r_empty;

   logic             w_do_push;
   logic             w_do_pop;
   logic [AW:0]      w_count_next;

   // Pushes into a full FIFO and pops from an empty one are dropped
   assign w_do_push = i_push && !r_full && !i_flush;
   assign w_do_pop  = i_pop && !r_empty && !i_flush;

   // Occupancy after this cycle's push/pop
   always_comb begin
      w_count_next = r_count;
      case ({w_do_push, w_do_pop})
         2'b10:   w_count_next = r_count + (AW+1)'(1);
         2'b01:   w_count_next = r_count - (AW+1)'(1);
         default: w_count_next = r_count;
      endcase
   end

   // Pointer, occupancy and flag registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: clocked state is always assigned with <= so every register samples pre-edge values.
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_next;
         r_full  <= (w_count_next == FULL_COUNT);
         r_empty <= (w_count_next == '0);
      end
   end

   // Storage write port
   always_ff @(posedge i_clk) begin
      // NOTE: storage has no reset; the empty flag guarantees stale entries are never read.
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/lcd_pixel_writer.sv
// Converts a stream of RGB888 pixels to RGB565 and writes them to an
// 8080-style LCD. Each frame starts with the CASET/PASET/RAMWR window
// sequence, then streams exactly the window's pixel count.
module lcd_pixel_writer
   import lcd_pkg::*;
#(
   parameter int WR_LOW_CYCLES  = 2,
   parameter int WR_HIGH_CYCLES = 2,
   parameter int FIFO_DEPTH     = 4,
   parameter int COORD_W        = 9
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               FRAME_START,
   input  logic [COORD_W-1:0] X0,
   input  logic [COORD_W-1:0] X1,
   input  logic [COORD_W-1:0] Y0,
   input  logic [COORD_W-1:0] Y1,
   input  logic [23:0]        PIXEL_IN,
   input  logic               PIXEL_VALID,
   output logic               PIXEL_READY,
   output logic               BUSY,
   output logic               FRAME_DONE,
   output logic               WIN_ERR,
   output logic               LCD_CS_N,
   output logic               LCD_DC,
   output logic               LCD_WR_N,
   output logic               LCD_RD_N,
   output logic [15:0]        LCD_DATA
);

   localparam int WORD_CYCLES = WR_LOW_CYCLES + WR_HIGH_CYCLES;
   localparam int PH_W        = (WORD_CYCLES > 2) ? $clog2(WORD_CYCLES) : 1;
   // One bit beyond 2*COORD_W so a full-range window's count (2^(2*COORD_W)) fits
   localparam int CNT_W       = 2 * COORD_W + 1;

   localparam logic [PH_W-1:0]  PH_LOW_LAST  = PH_W'(WR_LOW_CYCLES - 1);
   localparam logic [PH_W-1:0]  PH_WORD_LAST = PH_W'(WORD_CYCLES - 1);
   localparam logic [COORD_W:0] SPAN_ONE     = (COORD_W+1)'(1);

   lcd_state_e         r_state;
   lcd_state_e         w_state_next;

   logic [COORD_W-1:0] r_x0, r_x1, r_y0, r_y1;
   logic [CNT_W-1:0]   r_pix_cnt;   // pixels still to be popped and written
   logic [CNT_W-1:0]   r_acc_cnt;   // pixels still to be accepted from upstream
   logic [3:0]         r_step;

   logic               r_bus_active;
   logic [PH_W-1:0]    r_phase;
   logic               r_wr_n;
   logic               r_dc;
   logic [15:0]        r_data;
   logic               r_cs_n;
   logic               r_busy;
   logic               r_frame_done;
   logic               r_win_err;

   logic               w_bus_free;
   logic               w_win_ok;
   logic [COORD_W:0]   w_width;
   logic [COORD_W:0]   w_height;
   logic [CNT_W-1:0]   w_frame_pixels;
   logic [15:0]        w_x0_16, w_x1_16, w_y0_16, w_y1_16;
   logic [15:0]        w_set_win_word;
   logic               w_set_win_dc;

   logic               w_start;
   logic [15:0]        w_word;
   logic               w_word_dc;
   logic               w_pop;
   logic               w_flush;
   logic               w_load;
   logic               w_win_err;
   logic               w_ready;
   logic               w_push;
   logic               w_in_frame_next;

   logic [23:0]        w_fifo_dout;
   logic               w_fifo_full;
   logic               w_fifo_empty;

   pixel_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (24)
   ) u_fifo (
      .i_clk   (CLK),
      .i_rst_n (RESET),
      .i_push  (w_push),
      .i_data  (PIXEL_IN),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .o_data  (w_fifo_dout),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // Window geometry from the inputs sampled with FRAME_START
   assign w_win_ok       = (X1 >= X0) && (Y1 >= Y0);
   assign w_width        = {1'b0, X1} - {1'b0, X0} + SPAN_ONE;
   assign w_height       = {1'b0, Y1} - {1'b0, Y0} + SPAN_ONE;
   assign w_frame_pixels = CNT_W'(w_width) * CNT_W'(w_height);

   assign w_x0_16 = 16'(r_x0);
   assign w_x1_16 = 16'(r_x1);
   assign w_y0_16 = 16'(r_y0);
   assign w_y1_16 = 16'(r_y1);

   // The bus can take a new word when idle or in the last cycle of the current one
   assign w_bus_free = !r_bus_active || (r_phase == PH_WORD_LAST);

   // Upstream is held off outside a frame and once the frame's pixels are all accepted
   assign w_ready = (r_state != ST_IDLE) && !w_fifo_full && (r_acc_cnt != '0);
   assign w_push  = PIXEL_VALID && w_ready;

   // Word and DC for the current step of the window-setting sequence
   always_comb begin
      w_set_win_word = 16'h0000;
      w_set_win_dc   = 1'b1;
      case (r_step)
         4'd0:    begin w_set_win_word = {8'h00, CMD_CASET}; w_set_win_dc = 1'b0; end
         4'd1:    w_set_win_word = {8'h00, w_x0_16[15:8]};
         4'd2:    w_set_win_word = {8'h00, w_x0_16[7:0]};
         4'd3:    w_set_win_word = {8'h00, w_x1_16[15:8]};
         4'd4:    w_set_win_word = {8'h00, w_x1_16[7:0]};
         4'd5:    begin w_set_win_word = {8'h00, CMD_PASET}; w_set_win_dc = 1'b0; end
         4'd6:    w_set_win_word = {8'h00, w_y0_16[15:8]};
         4'd7:    w_set_win_word = {8'h00, w_y0_16[7:0]};
         4'd8:    w_set_win_word = {8'h00, w_y1_16[15:8]};
         4'd9:    w_set_win_word = {8'h00, w_y1_16[7:0]};
         4'd10:   begin w_set_win_word = {8'h00, CMD_RAMWR}; w_set_win_dc = 1'b0; end
         default: w_set_win_word = 16'h0000;
      endcase
   end

   // Controller state register
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic and per-cycle control strobes
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      w_state_next = r_state;
      w_start      = 1'b0;
      w_word       = 16'h0000;
      w_word_dc    = 1'b1;
      w_pop        = 1'b0;
      w_flush      = 1'b0;
      w_load       = 1'b0;
      w_win_err    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (FRAME_START) begin
               if (w_win_ok) begin
                  w_load       = 1'b1;
                  w_state_next = ST_SET_WIN;
               end else begin
                  w_win_err = 1'b1;
               end
            end
         end
         ST_SET_WIN: begin
            if (w_bus_free) begin
               w_start   = 1'b1;
               w_word    = w_set_win_word;
               w_word_dc = w_set_win_dc;
               if (r_step == LAST_WIN_STEP) w_state_next = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (w_bus_free) begin
               if (r_pix_cnt == '0) begin
                  w_state_next = ST_FINISH;
               end else if (!w_fifo_empty) begin
                  w_pop     = 1'b1;
                  w_start   = 1'b1;
                  w_word    = rgb888_to_565(w_fifo_dout);
                  w_word_dc = 1'b1;
               end
            end
         end
         ST_FINISH: begin
            w_flush      = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Frame bookkeeping: latched window, pixel counters and sequence step
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_x0      <= '0;
         r_x1      <= '0;
         r_y0      <= '0;
         r_y1      <= '0;
         r_pix_cnt <= '0;
         r_acc_cnt <= '0;
         r_step    <= '0;
      end else if (w_load) begin
         r_x0      <= X0;
         r_x1      <= X1;
         r_y0      <= Y0;
         r_y1      <= Y1;
         r_pix_cnt <= w_frame_pixels;
         r_acc_cnt <= w_frame_pixels;
         r_step    <= '0;
      end else begin
         if (w_pop)  r_pix_cnt <= r_pix_cnt - CNT_W'(1);
         if (w_push) r_acc_cnt <= r_acc_cnt - CNT_W'(1);
         if (w_start && (r_state == ST_SET_WIN)) r_step <= r_step + 4'd1;
      end
   end

   // Bus write primitive: data/DC launched with WR_N low, WR_N rises after the low phase
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_bus_active <= 1'b0;
         r_phase      <= '0;
         r_wr_n       <= 1'b1;
         r_dc         <= 1'b1;
         r_data       <= 16'h0000;
      end else if (w_start) begin
         r_bus_active <= 1'b1;
         r_phase      <= '0;
         r_wr_n       <= 1'b0;
         r_dc         <= w_word_dc;
         r_data       <= w_word;
      end else if (r_bus_active) begin
         if (r_phase == PH_WORD_LAST) begin
            r_bus_active <= 1'b0;
            r_phase      <= '0;
         end else begin
            r_phase <= r_phase + PH_W'(1);
         end
         if (r_phase == PH_LOW_LAST) r_wr_n <= 1'b1;
      end
   end

   assign w_in_frame_next = (w_state_next == ST_SET_WIN) || (w_state_next == ST_STREAM);

   // Registered frame status so CS_N, BUSY and the pulses are glitch-free
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_cs_n       <= 1'b1;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_win_err    <= 1'b0;
      end else begin
         r_cs_n       <= !w_in_frame_next;
         r_busy       <= w_in_frame_next;
         r_frame_done <= (w_state_next == ST_FINISH);
         r_win_err    <= w_win_err;
      end
   end

   assign PIXEL_READY = w_ready;
   assign BUSY        = r_busy;
   assign FRAME_DONE  = r_frame_done;
   assign WIN_ERR     = r_win_err;
   assign LCD_CS_N    = r_cs_n;
   assign LCD_DC      = r_dc;
   assign LCD_WR_N    = r_wr_n;
   assign LCD_RD_N    = 1'b1;
   assign LCD_DATA    = r_data;

endmodule

// File: tb/tb_lcd_pixel_writer.sv
// Scoreboard bench for lcd_pixel_writer: expected bus words are queued as
// stimulus is issued; monitors pop and compare at each WR_N rising edge.
// Instance a uses default 2/2 write timing, instance b uses 1/1.
module tb_lcd_pixel_writer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        a_start, a_valid, a_ready, a_busy, a_done, a_err;
   logic        a_cs_n, a_dc, a_wr_n, a_rd_n;
   logic [8:0]  a_x0, a_x1, a_y0, a_y1;
   logic [23:0] a_pix;
   logic [15:0] a_data;

   logic        b_start, b_valid, b_ready, b_busy, b_done, b_err;
   logic        b_cs_n, b_dc, b_wr_n, b_rd_n;
   logic [8:0]  b_x0, b_x1, b_y0, b_y1;
   logic [23:0] b_pix;
   logic [15:0] b_data;

   lcd_pixel_writer dut_a (
      .CLK(clk), .RESET(rst_n), .FRAME_START(a_start),
      .X0(a_x0), .X1(a_x1), .Y0(a_y0), .Y1(a_y1),
      .PIXEL_IN(a_pix), .PIXEL_VALID(a_valid), .PIXEL_READY(a_ready),
      .BUSY(a_busy), .FRAME_DONE(a_done), .WIN_ERR(a_err),
      .LCD_CS_N(a_cs_n), .LCD_DC(a_dc), .LCD_WR_N(a_wr_n),
      .LCD_RD_N(a_rd_n), .LCD_DATA(a_data)
   );

   lcd_pixel_writer #(.WR_LOW_CYCLES(1), .WR_HIGH_CYCLES(1)) dut_b (
      .CLK(clk), .RESET(rst_n), .FRAME_START(b_start),
      .X0(b_x0), .X1(b_x1), .Y0(b_y0), .Y1(b_y1),
      .PIXEL_IN(b_pix), .PIXEL_VALID(b_valid), .PIXEL_READY(b_ready),
      .BUSY(b_busy), .FRAME_DONE(b_done), .WIN_ERR(b_err),
      .LCD_CS_N(b_cs_n), .LCD_DC(b_dc), .LCD_WR_N(b_wr_n),
      .LCD_RD_N(b_rd_n), .LCD_DATA(b_data)
   );

   int n_checks = 0;
   int n_err    = 0;

   logic [16:0] a_q[$];
   logic [16:0] b_q[$];
   int a_fall = 0, a_words = 0, a_done_cnt = 0, a_cs_glitch = 0, a_low = 0;
   int b_done_cnt = 0, b_low = 0;
   bit a_prev_wr = 1'b1, b_prev_wr = 1'b1, a_in_frame = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic extra_word(input string name, input logic dc, input logic [15:0] data);
      n_checks++;
      n_err++;
      $display("FAIL %s: got dc=%b data=%h expected no word (t=%0t)", name, dc, data, $time);
   endtask

   // Monitor for instance a: compare each word as the panel would latch it
   always @(negedge clk) begin
      if (!rst_n) begin
         a_prev_wr  = 1'b1;
         a_low      = 0;
         a_in_frame = 1'b0;
      end else begin
         if (a_prev_wr && !a_wr_n) a_fall++;
         if (!a_prev_wr && a_wr_n) begin
            a_words++;
            if (a_q.size() == 0) extra_word("a_extra_word", a_dc, a_data);
            else check("a_word", {15'd0, a_dc, a_data}, {15'd0, a_q.pop_front()});
            check("a_wr_low_cycles", 32'(a_low), 32'd2);
         end
         a_low = a_wr_n ? 0 : a_low + 1;
         if (a_done) begin
            a_done_cnt++;
            a_in_frame = 1'b0;
         end else if (a_in_frame && a_cs_n) begin
            a_cs_glitch++;
         end
         a_prev_wr = a_wr_n;
      end
   end

   // Monitor for instance b (1-cycle low / 1-cycle high timing)
   always @(negedge clk) begin
      if (!rst_n) begin
         b_prev_wr = 1'b1;
         b_low     = 0;
      end else begin
         if (!b_prev_wr && b_wr_n) begin
            if (b_q.size() == 0) extra_word("b_extra_word", b_dc, b_data);
            else check("b_word", {15'd0, b_dc, b_data}, {15'd0, b_q.pop_front()});
            check("b_wr_low_cycles", 32'(b_low), 32'd1);
         end
         b_low = b_wr_n ? 0 : b_low + 1;
         if (b_done) b_done_cnt++;
         b_prev_wr = b_wr_n;
      end
   end

   // Queue the 11-word window sequence for a given window
   task automatic push_win(input bit to_b, input logic [8:0] x0, x1, y0, y1);
      logic [16:0] w[11];
      w[0]  = {1'b0, 16'h002A};
      w[1]  = {1'b1, 8'h00, 7'd0, x0[8]};
      w[2]  = {1'b1, 8'h00, x0[7:0]};
      w[3]  = {1'b1, 8'h00, 7'd0, x1[8]};
      w[4]  = {1'b1, 8'h00, x1[7:0]};
      w[5]  = {1'b0, 16'h002B};
      w[6]  = {1'b1, 8'h00, 7'd0, y0[8]};
      w[7]  = {1'b1, 8'h00, y0[7:0]};
      w[8]  = {1'b1, 8'h00, 7'd0, y1[8]};
      w[9]  = {1'b1, 8'h00, y1[7:0]};
      w[10] = {1'b0, 16'h002C};
      for (int i = 0; i < 11; i++) begin
         if (to_b) b_q.push_back(w[i]);
         else      a_q.push_back(w[i]);
      end
   endtask

   // Pulse FRAME_START; returns at the negedge just after the sampling edge
   task automatic start_a(input logic [8:0] x0, x1, y0, y1);
      @(negedge clk);
      a_x0 = x0; a_x1 = x1; a_y0 = y0; a_y1 = y1; a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
   endtask

   task automatic start_b(input logic [8:0] x0, x1, y0, y1);
      @(negedge clk);
      b_x0 = x0; b_x1 = x1; b_y0 = y0; b_y1 = y1; b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
   endtask

   // Offer one pixel after some idle cycles; transfer happens at the posedge after READY is seen
   task automatic send_a(input logic [23:0] p, input int idle);
      int t;
      t = 0;
      for (int k = 0; k < idle; k++) begin
         @(negedge clk);
         a_valid = 1'b0;
      end
      @(negedge clk);
      a_pix = p;
      a_valid = 1'b1;
      while (!a_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) check("a_ready_timeout", 32'(a_ready), 32'd1);
   endtask

   task automatic send_b(input logic [23:0] p);
      int t;
      t = 0;
      @(negedge clk);
      b_pix = p;
      b_valid = 1'b1;
      while (!b_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) check("b_ready_timeout", 32'(b_ready), 32'd1);
   endtask

   task automatic wait_done_a(input int budget);
      int t;
      t = 0;
      while (!a_done && t < budget) begin
         @(negedge clk);
         t++;
      end
      check("a_frame_done_seen", 32'(a_done), 32'd1);
   endtask

   task automatic wait_done_b(input int budget);
      int t;
      t = 0;
      while (!b_done && t < budget) begin
         @(negedge clk);
         t++;
      end
      check("b_frame_done_seen", 32'(b_done), 32'd1);
   endtask

   initial begin
      logic [23:0] p;
      int done0, words0, fall0;

      a_start = 0; a_valid = 0; a_pix = '0; a_x0 = '0; a_x1 = '0; a_y0 = '0; a_y1 = '0;
      b_start = 0; b_valid = 0; b_pix = '0; b_x0 = '0; b_x1 = '0; b_y0 = '0; b_y1 = '0;

      // Reset values
      repeat (2) @(negedge clk);
      check("a_reset_ctrl", 32'({a_cs_n, a_dc, a_wr_n, a_rd_n, a_ready, a_busy, a_done, a_err}), 32'hF0);
      check("a_reset_data", 32'(a_data), 32'h0);
      check("b_reset_ctrl", 32'({b_cs_n, b_dc, b_wr_n, b_rd_n, b_ready, b_busy, b_done, b_err}), 32'hF0);
      rst_n = 1'b1;

      // Pixels offered in IDLE must not be taken
      @(negedge clk);
      a_pix = 24'hABCDEF;
      a_valid = 1'b1;
      repeat (4) @(negedge clk);
      check("a_ready_idle", 32'(a_ready), 32'd0);
      a_valid = 1'b0;
      check("a_idle_no_writes", 32'(a_fall), 32'd0);

      // Two-pixel frame: full word sequence, latency and completion
      push_win(1'b0, 9'd0, 9'd1, 9'd0, 9'd0);
      a_q.push_back({1'b1, 16'hF800});
      a_q.push_back({1'b1, 16'h07E0});
      start_a(9'd0, 9'd1, 9'd0, 9'd0);
      a_in_frame = 1'b1;
      check("a_start_busy_cs_wr", 32'({a_busy, a_cs_n, a_wr_n}), 32'b101);
      fork
         begin
            send_a(24'hFF0000, 0);
            send_a(24'h00FF00, 0);
            @(negedge clk);
            a_valid = 1'b0;
         end
         begin
            @(negedge clk);
            check("a_first_cmd_wr_low", 32'({a_wr_n, a_dc, a_data}), {15'd0, 17'h0002A});
            repeat (43) @(negedge clk);
            check("a_wr_high_before_pixel", 32'(a_wr_n), 32'd1);
            @(negedge clk);
            check("a_first_pixel_latency", 32'({a_wr_n, a_data}), 32'h0F800);
         end
      join
      wait_done_a(200);
      check("a_done_cs_high", 32'(a_cs_n), 32'd1);
      @(negedge clk);
      check("a_done_one_cycle", 32'({a_done, a_busy, a_cs_n}), 32'b001);
      check("a_done_count_1", 32'(a_done_cnt), 32'd1);
      check("a_queue_empty_1", 32'(a_q.size()), 32'd0);

      // 10x10 window with gated input: FIFO underruns must not glitch WR_N or CS_N
      push_win(1'b0, 9'd3, 9'd12, 9'd20, 9'd29);
      for (int i = 0; i < 100; i++) begin
         p = {8'(i * 7 + 5), 8'(i * 13 + 1), 8'(i * 29 + 3)};
         a_q.push_back({1'b1, p[23:19], p[15:10], p[7:3]});
      end
      words0 = a_words;
      a_cs_glitch = 0;
      start_a(9'd3, 9'd12, 9'd20, 9'd29);
      a_in_frame = 1'b1;
      for (int i = 0; i < 100; i++) begin
         p = {8'(i * 7 + 5), 8'(i * 13 + 1), 8'(i * 29 + 3)};
         send_a(p, (i % 10 == 9) ? 11 : 3);
      end
      @(negedge clk);
      a_valid = 1'b0;
      wait_done_a(5000);
      @(negedge clk);
      check("a_10x10_word_count", 32'(a_words - words0), 32'd111);
      check("a_10x10_cs_low", 32'(a_cs_glitch), 32'd0);
      check("a_done_count_2", 32'(a_done_cnt), 32'd2);
      check("a_queue_empty_2", 32'(a_q.size()), 32'd0);

      // Bad window: error pulse, no frame, no bus activity
      fall0 = a_fall;
      start_a(9'd5, 9'd4, 9'd0, 9'd0);
      check("a_win_err_pulse", 32'({a_err, a_busy}), 32'b10);
      @(negedge clk);
      check("a_win_err_clear", 32'(a_err), 32'd0);
      repeat (10) @(negedge clk);
      check("a_win_err_no_writes", 32'(a_fall - fall0), 32'd0);
      check("a_win_err_idle", 32'({a_busy, a_cs_n}), 32'b01);

      // Reset during SET_WIN step 6, then a clean restart
      done0 = a_done_cnt;
      push_win(1'b0, 9'd4, 9'd7, 9'd1, 9'd2);
      start_a(9'd4, 9'd7, 9'd1, 9'd2);
      repeat (26) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("a_async_reset_ctrl", 32'({a_cs_n, a_dc, a_wr_n, a_rd_n, a_ready, a_busy, a_done, a_err}), 32'hF0);
      check("a_async_reset_data", 32'(a_data), 32'h0);
      check("a_abort_words_left", 32'(a_q.size()), 32'd5);
      a_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("a_abort_no_done", 32'(a_done_cnt), 32'(done0));
      push_win(1'b0, 9'd2, 9'd2, 9'd3, 9'd3);
      a_q.push_back({1'b1, 16'h11AA});
      start_a(9'd2, 9'd2, 9'd3, 9'd3);
      @(negedge clk);
      check("a_restart_first_cmd", 32'({a_wr_n, a_dc, a_data}), {15'd0, 17'h0002A});
      send_a(24'h123456, 0);
      @(negedge clk);
      a_valid = 1'b0;
      wait_done_a(300);
      @(negedge clk);
      check("a_restart_done", 32'(a_done_cnt), 32'(done0 + 1));
      check("a_queue_empty_3", 32'(a_q.size()), 32'd0);

      // Fast-timing instance: blue and white pixels, 1-cycle strobes
      push_win(1'b1, 9'd0, 9'd1, 9'd0, 9'd0);
      b_q.push_back({1'b1, 16'h001F});
      b_q.push_back({1'b1, 16'hFFFF});
      start_b(9'd0, 9'd1, 9'd0, 9'd0);
      @(negedge clk);
      check("b_first_cmd_wr_low", 32'({b_wr_n, b_dc, b_data}), {15'd0, 17'h0002A});
      send_b(24'h0000FF);
      send_b(24'hFFFFFF);
      @(negedge clk);
      b_valid = 1'b0;
      wait_done_b(300);
      @(negedge clk);
      check("b_done_count", 32'(b_done_cnt), 32'd1);
      check("b_queue_empty", 32'(b_q.size()), 32'd0);
      check("b_idle_after", 32'({b_cs_n, b_busy, b_rd_n}), 32'b101);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
